// File: rtl/stream_demultiplexer_if.sv
// rtl/stream_demultiplexer_if.sv - valid/ready bundle between a shared producer, the demultiplexer and its lane consumers
interface stream_demultiplexer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OUTPUTS = 4,
    parameter int SEL_WIDTH   = 2
);
    logic [DATA_WIDTH-1:0]             data_in;
    logic [SEL_WIDTH-1:0]              select_in;
    logic                              valid_in;
    logic                              ready_out;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_out;
    logic [NUM_OUTPUTS-1:0]            valid_out;
    logic [NUM_OUTPUTS-1:0]            ready_in;
    logic                              error_out;

    // master: the environment (producer plus lane consumers); slave: the demultiplexer
    modport master (
        output data_in, select_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, error_out
    );

    modport slave (
        input  data_in, select_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, error_out
    );
endinterface

// File: rtl/stream_demultiplexer.sv
// rtl/stream_demultiplexer.sv - one-entry buffered 1-to-N stream demultiplexer; DEMUX_DROP_COUNT_EN adds drop_count
module stream_demultiplexer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OUTPUTS = 4,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    stream_demultiplexer_if.slave bus
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH:0] LANE_LIMIT = (SEL_WIDTH + 1)'(NUM_OUTPUTS);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  error_q;

    logic in_range;
    logic in_xfer;
    logic lane_ready;
    logic lane_xfer;
    logic load;

    assign in_range   = ({1'b0, bus.select_in} < LANE_LIMIT);
    assign lane_ready = bus.ready_in[sel_q];

    // Ready follows the held lane's consumer so a draining beat can be replaced in the same cycle.
    assign bus.ready_out = ~reset & ((state_q == EMPTY) | lane_ready);
    assign in_xfer       = bus.valid_in & bus.ready_out;
    assign lane_xfer     = (state_q == FULL) & lane_ready;
    assign load          = in_xfer & in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= in_xfer & ~in_range;
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        data_q  <= bus.data_in;
                        sel_q   <= bus.select_in;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (lane_xfer) begin
                        if (load) begin
                            data_q <= bus.data_in;
                            sel_q  <= bus.select_in;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.valid_out = '0;
        bus.data_out  = '0;
        if (!reset && state_q == FULL) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (sel_q == SEL_WIDTH'(k)) begin
                    bus.valid_out[k]                        = 1'b1;
                    bus.data_out[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
                end
            end
        end
    end

    assign bus.error_out = error_q & ~reset;

`ifdef DEMUX_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic [15:0] drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_xfer && !in_range && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb/tb_stream_demultiplexer.sv - directed and randomized checks of stream_demultiplexer against a one-deep FIFO model
module tb_stream_demultiplexer;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    stream_demultiplexer_if #(.DATA_WIDTH(8), .NUM_OUTPUTS(4), .SEL_WIDTH(2)) if4 ();
    stream_demultiplexer_if #(.DATA_WIDTH(8), .NUM_OUTPUTS(3), .SEL_WIDTH(2)) if3 ();

`ifdef DEMUX_DROP_COUNT_EN
    logic [15:0] dc4;
    logic [15:0] dc3;
`endif

    stream_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(4), .SEL_WIDTH(2)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .bus        (if4.slave)
`ifdef DEMUX_DROP_COUNT_EN
        ,
        .drop_count (dc4)
`endif
    );

    stream_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(3), .SEL_WIDTH(2)) dut3 (
        .clock      (clock),
        .reset      (reset),
        .bus        (if3.slave)
`ifdef DEMUX_DROP_COUNT_EN
        ,
        .drop_count (dc3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        step;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready4 got %b want 0", if4.ready_out); end
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL rst_valid4 got %b want 0000", if4.valid_out); end
        total++; if (if4.data_out !== 32'h0) begin bad++; $display("FAIL rst_data4 got %h want 0", if4.data_out); end
        total++; if (if4.error_out !== 1'b0) begin bad++; $display("FAIL rst_err4 got %b want 0", if4.error_out); end
        total++; if (if3.ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready3 got %b want 0", if3.ready_out); end
        step;
        reset = 1'b0;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b1) begin bad++; $display("FAIL post_rst_ready4 got %b want 1", if4.ready_out); end
        total++; if (if3.ready_out !== 1'b1) begin bad++; $display("FAIL post_rst_ready3 got %b want 1", if3.ready_out); end
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL post_rst_valid4 got %b want 0000", if4.valid_out); end
    endtask

    task automatic test_single;
        step;
        if4.ready_in  = 4'b1111;
        if4.data_in   = 8'hA5;
        if4.select_in = 2'd2;
        if4.valid_in  = 1'b1;
        step;
        if4.valid_in = 1'b0;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0100) begin bad++; $display("FAIL single_valid got %b want 0100", if4.valid_out); end
        total++; if (if4.data_out !== 32'h00A5_0000) begin bad++; $display("FAIL single_data got %h want 00a50000", if4.data_out); end
        step;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL single_drain got %b want 0000", if4.valid_out); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ev;
        logic [31:0] ed;
        if4.ready_in = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step;
            if4.data_in   = 8'(i + 1);
            if4.select_in = 2'(i);
            if4.valid_in  = 1'b1;
            @(negedge clock);
            ev = '0;
            ed = '0;
            if (i > 0) begin
                ev[i-1]          = 1'b1;
                ed[(i-1)*8 +: 8] = 8'(i);
            end
            total++; if (if4.ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, if4.ready_out); end
            total++; if (if4.valid_out !== ev) begin bad++; $display("FAIL b2b_valid[%0d] got %b want %b", i, if4.valid_out, ev); end
            total++; if (if4.data_out !== ed) begin bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, if4.data_out, ed); end
        end
        step;
        if4.valid_in = 1'b0;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b1000) begin bad++; $display("FAIL b2b_last_valid got %b want 1000", if4.valid_out); end
        total++; if (if4.data_out !== 32'h0400_0000) begin bad++; $display("FAIL b2b_last_data got %h want 04000000", if4.data_out); end
        step;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL b2b_drain got %b want 0000", if4.valid_out); end
    endtask

    task automatic test_stall;
        step;
        if4.ready_in  = 4'b1101;
        if4.data_in   = 8'h3C;
        if4.select_in = 2'd1;
        if4.valid_in  = 1'b1;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b1) begin bad++; $display("FAIL stall_load_ready got %b want 1", if4.ready_out); end
        step;
        if4.data_in   = 8'h5A;
        if4.select_in = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++; if (if4.ready_out !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, if4.ready_out); end
            total++; if (if4.valid_out !== 4'b0010) begin bad++; $display("FAIL stall_valid[%0d] got %b want 0010", i, if4.valid_out); end
            total++; if (if4.data_out !== 32'h0000_3C00) begin bad++; $display("FAIL stall_data[%0d] got %h want 00003c00", i, if4.data_out); end
            step;
        end
        if4.ready_in = 4'b1111;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", if4.ready_out); end
        step;
        if4.valid_in = 1'b0;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0001) begin bad++; $display("FAIL stall_next_valid got %b want 0001", if4.valid_out); end
        total++; if (if4.data_out !== 32'h0000_005A) begin bad++; $display("FAIL stall_next_data got %h want 0000005a", if4.data_out); end
        step;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL stall_drain got %b want 0000", if4.valid_out); end
    endtask

    task automatic test_out_of_range;
        step;
        if3.ready_in  = 3'b111;
        if3.data_in   = 8'hFF;
        if3.select_in = 2'd3;
        if3.valid_in  = 1'b1;
        @(negedge clock);
        total++; if (if3.ready_out !== 1'b1) begin bad++; $display("FAIL oor_ready got %b want 1", if3.ready_out); end
        total++; if (if3.error_out !== 1'b0) begin bad++; $display("FAIL oor_err_early got %b want 0", if3.error_out); end
        step;
        if3.valid_in = 1'b0;
        @(negedge clock);
        total++; if (if3.valid_out !== 3'b0) begin bad++; $display("FAIL oor_valid got %b want 000", if3.valid_out); end
        total++; if (if3.error_out !== 1'b1) begin bad++; $display("FAIL oor_err got %b want 1", if3.error_out); end
`ifdef DEMUX_DROP_COUNT_EN
        total++; if (dc3 !== 16'd1) begin bad++; $display("FAIL oor_drop_count got %0d want 1", dc3); end
`endif
        step;
        @(negedge clock);
        total++; if (if3.error_out !== 1'b0) begin bad++; $display("FAIL oor_err_once got %b want 0", if3.error_out); end
        total++; if (if3.valid_out !== 3'b0) begin bad++; $display("FAIL oor_valid_after got %b want 000", if3.valid_out); end
    endtask

    task automatic test_reset_mid;
        step;
        if4.ready_in  = 4'b0000;
        if4.data_in   = 8'h77;
        if4.select_in = 2'd3;
        if4.valid_in  = 1'b1;
        step;
        if4.data_in   = 8'h88;
        if4.select_in = 2'd0;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b1000) begin bad++; $display("FAIL rmid_full got %b want 1000", if4.valid_out); end
        total++; if (if4.ready_out !== 1'b0) begin bad++; $display("FAIL rmid_stalled got %b want 0", if4.ready_out); end
        step;
        reset = 1'b1;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b0) begin bad++; $display("FAIL rmid_rst_ready got %b want 0", if4.ready_out); end
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL rmid_rst_valid got %b want 0000", if4.valid_out); end
        total++; if (if4.data_out !== 32'h0) begin bad++; $display("FAIL rmid_rst_data got %h want 0", if4.data_out); end
        step;
        reset         = 1'b0;
        if4.valid_in  = 1'b0;
        if4.ready_in  = 4'b1111;
        @(negedge clock);
        total++; if (if4.ready_out !== 1'b1) begin bad++; $display("FAIL rmid_after_ready got %b want 1", if4.ready_out); end
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL rmid_lost got %b want 0000", if4.valid_out); end
        step;
        @(negedge clock);
        total++; if (if4.valid_out !== 4'b0) begin bad++; $display("FAIL rmid_lost2 got %b want 0000", if4.valid_out); end
    endtask

    task automatic test_random;
        beat_t       q[$];
        beat_t       b;
        logic        exp_err   = 1'b0;
        int          exp_drops = 0;
        logic        exp_ready;
        logic [2:0]  exp_valid;
        logic [23:0] exp_data;
        logic        in_x;
        for (int c = 0; c < 10000; c++) begin
            step;
            if (c >= 9980) begin
                if3.valid_in = 1'b0;
                if3.ready_in = 3'b111;
            end else begin
                if3.valid_in  = ($urandom_range(0, 3) != 0);
                if3.data_in   = 8'($urandom);
                if3.select_in = 2'($urandom_range(0, 3));
                if3.ready_in  = 3'($urandom);
            end
            @(negedge clock);
            exp_valid = '0;
            exp_data  = '0;
            exp_ready = 1'b1;
            if (q.size() > 0) begin
                exp_valid[q[0].sel]      = 1'b1;
                exp_data[q[0].sel*8 +: 8] = q[0].data;
                exp_ready                = if3.ready_in[q[0].sel];
            end
            total++; if (if3.ready_out !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got %b want %b", c, if3.ready_out, exp_ready); end
            total++; if (if3.valid_out !== exp_valid) begin bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, if3.valid_out, exp_valid); end
            total++; if (if3.data_out !== exp_data) begin bad++; $display("FAIL rnd_data c=%0d got %h want %h", c, if3.data_out, exp_data); end
            total++; if (if3.error_out !== exp_err) begin bad++; $display("FAIL rnd_err c=%0d got %b want %b", c, if3.error_out, exp_err); end
`ifdef DEMUX_DROP_COUNT_EN
            total++; if (dc3 !== 16'(exp_drops)) begin bad++; $display("FAIL rnd_drops c=%0d got %0d want %0d", c, dc3, exp_drops); end
`endif
            in_x    = if3.valid_in & exp_ready;
            exp_err = 1'b0;
            if (q.size() > 0 && if3.ready_in[q[0].sel]) begin
                void'(q.pop_front());
            end
            if (in_x) begin
                if (if3.select_in < 2'd3) begin
                    b.sel  = if3.select_in;
                    b.data = if3.data_in;
                    q.push_back(b);
                end else begin
                    exp_err = 1'b1;
                    if (exp_drops < 65535) exp_drops++;
                end
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drained got %0d want 0", q.size()); end
    endtask

    initial begin
        reset         = 1'b1;
        if4.data_in   = '0;
        if4.select_in = '0;
        if4.valid_in  = 1'b0;
        if4.ready_in  = 4'b1111;
        if3.data_in   = '0;
        if3.select_in = '0;
        if3.valid_in  = 1'b0;
        if3.ready_in  = 3'b111;
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_out_of_range;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
